// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared constants, op/state encodings and helpers for mem_stage
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam logic        STOP      = 1'b1;
  localparam logic        NO_STOP   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LBU = 3'b001,
    OP_LH  = 3'b010,
    OP_LHU = 3'b011,
    OP_LW  = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [1:0] op_size(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SIZE_HALF;
      default:              op_size = SIZE_WORD;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_op_e op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// ============================================================================
// mem_align : store byte-lane steering and load byte/half extraction/extension
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_align
  import mem_stage_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr_lo)
      2'd0:    w_byte = load_raw[7:0];
      2'd1:    w_byte = load_raw[15:8];
      2'd2:    w_byte = load_raw[23:16];
      default: w_byte = load_raw[31:24];
    endcase
    w_half = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
  end

  always_comb begin
    wstrb     = 4'b0000;
    wdata     = store_data;
    load_data = load_raw;
    case (op)
      OP_LB:  load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU: load_data = {24'h0, w_byte};
      OP_LH:  load_data = {{16{w_half[15]}}, w_half};
      OP_LHU: load_data = {16'h0, w_half};
      OP_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      OP_SW:  wstrb = 4'b1111;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : MIPS MEM stage - data-bus FSM, read buffer and result muxing.
//             Optional alignment exceptions under `define MEM_ALIGN_CHECK_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        i_write_mem,
  input  logic        i_write_regfile,
  input  logic        i_mem_to_regfile,
  input  logic [31:0] i_da,
  input  logic [31:0] i_db,
  input  logic [4:0]  i_rn,
  input  logic [7:0]  i_mem_control,
  output logic        o_write_regfile,
  output logic [4:0]  o_rn,
  output logic [31:0] o_wdata,
  output logic        o_stallreq,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        o_adel,
  output logic        o_ades,
  output logic [31:0] o_badvaddr
);

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_rbuf;
  logic        w_capture;
  mem_op_e     w_op;
  logic        w_active;
  logic        w_is_store;
  logic        w_is_load;
  logic        w_misalign;
  logic [31:0] w_load_data;

  assign w_op       = mem_op_e'(i_mem_control[2:0]);
  assign w_active   = i_write_mem | i_mem_to_regfile;
  assign w_is_store = op_is_store(w_op);
  assign w_is_load  = i_mem_to_regfile & ~w_is_store;

  assign o_rn      = i_rn;
  assign data_wr   = w_is_store;
  assign data_size = op_size(w_op);

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    case (w_op)
      OP_LH, OP_LHU, OP_SH: w_misalign = i_da[0];
      OP_LW, OP_SW:         w_misalign = (i_da[1:0] != 2'b00);
      default:              w_misalign = 1'b0;
    endcase
  end

  assign data_addr  = i_da;
  assign o_adel     = w_active & w_misalign & ~w_is_store;
  assign o_ades     = w_active & w_misalign &  w_is_store;
  assign o_badvaddr = (o_adel | o_ades) ? i_da : ZERO_WORD;
`else
  assign w_misalign = 1'b0;

  // Low address bits are forced aligned so the slave never sees a split access.
  always_comb begin
    case (data_size)
      SIZE_HALF: data_addr = {i_da[31:1], 1'b0};
      SIZE_WORD: data_addr = {i_da[31:2], 2'b00};
      default:   data_addr = i_da;
    endcase
  end

  assign o_adel     = 1'b0;
  assign o_ades     = 1'b0;
  assign o_badvaddr = ZERO_WORD;
`endif

  // Store steering uses the live store data; load extraction works on rbuf.
  mem_align u_mem_align (
    .op         (w_op),
    .addr_lo    (i_da[1:0]),
    .store_data (i_db),
    .load_raw   (r_rbuf),
    .wstrb      (data_wstrb),
    .wdata      (data_wdata),
    .load_data  (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rbuf  <= ZERO_WORD;
    end else begin
      r_state <= w_state_next;
      if (w_capture) r_rbuf <= data_rdata;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_capture       = 1'b0;
    data_req        = 1'b0;
    o_stallreq      = 1'b0;
    o_write_regfile = i_write_regfile;
    o_wdata         = i_da;

    case (r_state)
      ST_IDLE: begin
        if (w_active && !w_misalign) begin
          data_req   = 1'b1;
          o_stallreq = 1'b1;
          if (data_addr_ok) w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        o_stallreq = 1'b1;
        if (data_data_ok) begin
          w_capture    = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (stall[4] == NO_STOP) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Loads only expose a result once rbuf holds it; stores never write back.
    if (w_active) begin
      o_write_regfile = 1'b0;
      if (r_state == ST_DONE && w_is_load) begin
        o_write_regfile = i_write_regfile;
        o_wdata         = w_load_data;
      end
    end
  end

  logic w_unused;
  assign w_unused = &{1'b0, stall[5], stall[3:0], i_mem_control[7:3]};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for combinational behaviour
// plus hand-written multi-cycle bus sequences.
`default_nettype none

module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [5:0]  stall;
  logic        i_write_mem, i_write_regfile, i_mem_to_regfile;
  logic [31:0] i_da, i_db;
  logic [4:0]  i_rn;
  logic [7:0]  i_mem_control;
  logic        o_write_regfile;
  logic [4:0]  o_rn;
  logic [31:0] o_wdata;
  logic        o_stallreq, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        o_adel, o_ades;
  logic [31:0] o_badvaddr;

  int total = 0;
  int bad   = 0;
  int n_hs  = 0;
  int hs_base;

  mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .i_write_mem(i_write_mem), .i_write_regfile(i_write_regfile),
    .i_mem_to_regfile(i_mem_to_regfile), .i_da(i_da), .i_db(i_db),
    .i_rn(i_rn), .i_mem_control(i_mem_control),
    .o_write_regfile(o_write_regfile), .o_rn(o_rn), .o_wdata(o_wdata),
    .o_stallreq(o_stallreq), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .o_adel(o_adel), .o_ades(o_ades), .o_badvaddr(o_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (data_req && data_addr_ok) n_hs++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  typedef struct {
    logic        wm, wr, m2r;
    logic [31:0] da, db;
    logic [4:0]  rn;
    logic [2:0]  op;
    logic        e_req, e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_bwd;
    logic        e_stall, e_wreg;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wm, input logic wr, input logic m2r,
                       input logic [31:0] da, input logic [31:0] db,
                       input logic [4:0] rn, input logic [2:0] op);
    i_write_mem      = wm;
    i_write_regfile  = wr;
    i_mem_to_regfile = m2r;
    i_da             = da;
    i_db             = db;
    i_rn             = rn;
    i_mem_control    = {5'b10101, op};
  endtask

  task automatic clear_in();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'b000);
    i_mem_control = 8'h00;
  endtask

  // One load through the bus with zero-wait addr_ok and next-cycle data_ok.
  task automatic load_seq(input logic [2:0] op, input logic [31:0] da,
                          input logic [31:0] rdata, input logic [31:0] exp_wd,
                          input string nm);
    drive(1'b0, 1'b1, 1'b1, da, 32'h0, 5'd7, op);
    data_addr_ok = 1'b1;
    #1;
    chk({nm, " idle req"}, 32'(data_req), 32'd1);
    chk({nm, " idle stall"}, 32'(o_stallreq), 32'd1);
    chk({nm, " idle wreg"}, 32'(o_write_regfile), 32'd0);
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    #1;
    chk({nm, " wait req"}, 32'(data_req), 32'd0);
    chk({nm, " wait stall"}, 32'(o_stallreq), 32'd1);
    chk({nm, " wait wreg"}, 32'(o_write_regfile), 32'd0);
    tick();
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    #1;
    chk({nm, " done stall"}, 32'(o_stallreq), 32'd0);
    chk({nm, " done wreg"}, 32'(o_write_regfile), 32'd1);
    chk({nm, " done wdata"}, o_wdata, exp_wd);
    chk({nm, " done rn"}, 32'(o_rn), 32'd7);
  endtask

  initial begin
    reset = 1'b1;
    stall = 6'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    clear_in();

    vecs[0] = '{1'b0,1'b1,1'b0, 32'h0000_1234, 32'h0, 5'd5, 3'b000,
                1'b0,1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0,1'b1, 32'h0000_1234};
    vecs[1] = '{1'b0,1'b0,1'b0, 32'hDEAD_BEEF, 32'h1, 5'd9, 3'b100,
                1'b0,1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0,1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1,1'b0,1'b0, 32'h0000_1001, 32'h1234_5678, 5'd1, 3'b101,
                1'b1,1'b1, 2'd0, 32'h0000_1001, 4'b0010, 32'h7878_7878, 1'b1,1'b0, 32'h0};
    vecs[3] = '{1'b1,1'b0,1'b0, 32'h0000_1003, 32'h1234_56A5, 5'd1, 3'b101,
                1'b1,1'b1, 2'd0, 32'h0000_1003, 4'b1000, 32'hA5A5_A5A5, 1'b1,1'b0, 32'h0};
    vecs[4] = '{1'b1,1'b0,1'b0, 32'h0000_2002, 32'hAAAA_BEEF, 5'd2, 3'b110,
                1'b1,1'b1, 2'd1, 32'h0000_2002, 4'b1100, 32'hBEEF_BEEF, 1'b1,1'b0, 32'h0};
    vecs[5] = '{1'b1,1'b0,1'b0, 32'h0000_2000, 32'h5555_1234, 5'd2, 3'b110,
                1'b1,1'b1, 2'd1, 32'h0000_2000, 4'b0011, 32'h1234_1234, 1'b1,1'b0, 32'h0};
    vecs[6] = '{1'b1,1'b0,1'b0, 32'h0000_4000, 32'hCAFE_F00D, 5'd3, 3'b111,
                1'b1,1'b1, 2'd2, 32'h0000_4000, 4'b1111, 32'hCAFE_F00D, 1'b1,1'b0, 32'h0};
    vecs[7] = '{1'b0,1'b1,1'b1, 32'h0000_5004, 32'h0, 5'd4, 3'b100,
                1'b1,1'b0, 2'd2, 32'h0000_5004, 4'h0, 32'h0, 1'b1,1'b0, 32'h0};
    vecs[8] = '{1'b0,1'b1,1'b1, 32'h0000_6002, 32'h0, 5'd6, 3'b011,
                1'b1,1'b0, 2'd1, 32'h0000_6002, 4'h0, 32'h0, 1'b1,1'b0, 32'h0};

    // Reset state with zeroed EXE/MEM inputs
    repeat (2) tick();
    chk("rst req", 32'(data_req), 32'd0);
    chk("rst stall", 32'(o_stallreq), 32'd0);
    chk("rst adel", 32'(o_adel), 32'd0);
    chk("rst ades", 32'(o_ades), 32'd0);
    chk("rst badv", o_badvaddr, 32'h0);
    chk("rst wreg", 32'(o_write_regfile), 32'd0);
    chk("rst rn", 32'(o_rn), 32'd0);
    chk("rst wdata", o_wdata, 32'h0);
    reset = 1'b0;
    tick();

    // Vector table: addr_ok held low so the FSM stays in IDLE
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].wm, vecs[i].wr, vecs[i].m2r, vecs[i].da, vecs[i].db,
            vecs[i].rn, vecs[i].op);
      #1;
      chk($sformatf("v%0d req", i), 32'(data_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d stall", i), 32'(o_stallreq), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d wreg", i), 32'(o_write_regfile), 32'(vecs[i].e_wreg));
      chk($sformatf("v%0d rn", i), 32'(o_rn), 32'(vecs[i].rn));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d wr", i), 32'(data_wr), 32'(vecs[i].e_wr));
        chk($sformatf("v%0d size", i), 32'(data_size), 32'(vecs[i].e_size));
        chk($sformatf("v%0d addr", i), data_addr, vecs[i].e_addr);
      end
      if (vecs[i].e_wr) begin
        chk($sformatf("v%0d wstrb", i), 32'(data_wstrb), 32'(vecs[i].e_strb));
        chk($sformatf("v%0d bus wdata", i), data_wdata, vecs[i].e_bwd);
      end
      if (!vecs[i].e_stall)
        chk($sformatf("v%0d wdata", i), o_wdata, vecs[i].e_wd);
      #1;
    end
    clear_in();
    tick();

    // LB then LBU at 0x1003; LBU also holds in DONE under an MEM/WB stop
    load_seq(3'b000, 32'h0000_1003, 32'h80FF_FF00, 32'hFFFF_FF80, "lb");
    tick();
    load_seq(3'b001, 32'h0000_1003, 32'h80FF_FF00, 32'h0000_0080, "lbu");
    stall = 6'b010000;
    tick();
    chk("lbu hold wdata", o_wdata, 32'h0000_0080);
    chk("lbu hold wreg", 32'(o_write_regfile), 32'd1);
    chk("lbu hold stall", 32'(o_stallreq), 32'd0);
    chk("lbu hold req", 32'(data_req), 32'd0);
    stall = 6'b0;
    tick();
    load_seq(3'b010, 32'h0000_1002, 32'h8001_7F00, 32'hFFFF_8001, "lh");
    tick();
    clear_in();
    tick();

    // SH at 0x2002: store never writes back, even in DONE
    drive(1'b1, 1'b1, 1'b0, 32'h0000_2002, 32'hAAAA_BEEF, 5'd8, 3'b110);
    data_addr_ok = 1'b1;
    #1;
    chk("sh data_wr", 32'(data_wr), 32'd1);
    chk("sh idle wreg", 32'(o_write_regfile), 32'd0);
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    #1;
    chk("sh done wreg", 32'(o_write_regfile), 32'd0);
    chk("sh done stall", 32'(o_stallreq), 32'd0);
    tick();
    clear_in();
    tick();

    // addr_ok held low 3 cycles, data_ok one cycle late
    hs_base = n_hs;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_5008, 32'h0, 5'd3, 3'b100);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d req", c), 32'(data_req), 32'd1);
      chk($sformatf("hold%0d addr", c), data_addr, 32'h0000_5008);
      chk($sformatf("hold%0d stall", c), 32'(o_stallreq), 32'd1);
      tick();
    end
    data_addr_ok = 1'b1;
    #1;
    chk("hold accept req", 32'(data_req), 32'd1);
    tick();
    data_addr_ok = 1'b0;
    #1;
    chk("hold wait1 req", 32'(data_req), 32'd0);
    chk("hold wait1 stall", 32'(o_stallreq), 32'd1);
    tick();
    data_data_ok = 1'b1;
    data_rdata   = 32'h1122_3344;
    #1;
    chk("hold wait2 stall", 32'(o_stallreq), 32'd1);
    tick();
    data_data_ok = 1'b0;
    #1;
    chk("hold done wdata", o_wdata, 32'h1122_3344);
    chk("hold done wreg", 32'(o_write_regfile), 32'd1);
    chk("hold done stall", 32'(o_stallreq), 32'd0);
    chk("hold handshakes", 32'(n_hs - hs_base), 32'd1);
    tick();
    clear_in();
    tick();

    // Reset while in WAIT, then a late data_ok must be ignored in IDLE
    drive(1'b0, 1'b1, 1'b1, 32'h0000_7000, 32'h0, 5'd2, 3'b100);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    #1;
    chk("rstw wait stall", 32'(o_stallreq), 32'd1);
    reset = 1'b1;
    clear_in();
    tick();
    chk("rstw req", 32'(data_req), 32'd0);
    chk("rstw stall", 32'(o_stallreq), 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_7004, 32'h0, 5'd2, 3'b100);
    data_data_ok = 1'b1;
    data_rdata   = 32'hFFFF_FFFF;
    #1;
    chk("late ok req", 32'(data_req), 32'd1);
    tick();
    data_data_ok = 1'b0;
    #1;
    chk("late ok still idle req", 32'(data_req), 32'd1);
    chk("late ok still idle stall", 32'(o_stallreq), 32'd1);
    chk("late ok wreg", 32'(o_write_regfile), 32'd0);
    clear_in();
    tick();

`ifdef MEM_ALIGN_CHECK_EN
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3001, 32'h0, 5'd4, 3'b100);
    #1;
    chk("lw mis adel", 32'(o_adel), 32'd1);
    chk("lw mis ades", 32'(o_ades), 32'd0);
    chk("lw mis badv", o_badvaddr, 32'h0000_3001);
    chk("lw mis req", 32'(data_req), 32'd0);
    chk("lw mis stall", 32'(o_stallreq), 32'd0);
    chk("lw mis wreg", 32'(o_write_regfile), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_2001, 32'h0, 5'd0, 3'b110);
    #1;
    chk("sh mis ades", 32'(o_ades), 32'd1);
    chk("sh mis adel", 32'(o_adel), 32'd0);
    chk("sh mis req", 32'(data_req), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_2002, 32'h0, 5'd4, 3'b010);
    #1;
    chk("lh ok adel", 32'(o_adel), 32'd0);
    chk("lh ok req", 32'(data_req), 32'd1);
`else
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3001, 32'h0, 5'd4, 3'b100);
    #1;
    chk("lw force addr", data_addr, 32'h0000_3000);
    chk("lw noalign adel", 32'(o_adel), 32'd0);
    chk("lw noalign badv", o_badvaddr, 32'h0);
    chk("lw noalign req", 32'(data_req), 32'd1);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_6001, 32'h0, 5'd4, 3'b011);
    #1;
    chk("lhu force addr", data_addr, 32'h0000_6000);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_2003, 32'h0, 5'd0, 3'b110);
    #1;
    chk("sh noalign ades", 32'(o_ades), 32'd0);
`endif
    clear_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, placed between the EXE/MEM register and the MEM/WB register. It turns load/store operations into transactions on the SRAM-like data bus and requests a pipeline stall while a transaction is outstanding. It steers store bytes and extracts/extends load data, and passes non-memory results through with zero latency. Its result outputs also serve as the MEM-stage forwarding source for ID.

## Interface
- No parameters; all constants come from `global_define.vh`.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- stall  in  6  pipeline stall vector; bit 4 (MEM/WB) is used, `Stop`=1
- i_write_mem  in  1  store qualifier from EXE/MEM
- i_write_regfile  in  1  register write enable from EXE/MEM
- i_mem_to_regfile  in  1  load qualifier
- i_da  in  32  ALU result / effective address
- i_db  in  32  store data (rt)
- i_rn  in  5  destination register
- i_mem_control  in  8  [2:0] op: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW; [7:3] reserved, ignored
- o_write_regfile  out  1  to MEM/WB and forwarding
- o_rn  out  5  destination register
- o_wdata  out  32  writeback value
- o_stallreq  out  1  stall request to pipeline controller
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  byte address
- data_wstrb  out  4  byte enables (writes)
- data_wdata  out  32  write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  read data
- o_adel, o_ades  out  1  load/store address error
- o_badvaddr  out  32  faulting address

## Operation
- An access is active when i_write_mem or i_mem_to_regfile is 1. Otherwise the stage passes through combinationally: o_wdata=i_da, o_write_regfile=i_write_regfile, o_rn=i_rn, o_stallreq=0, data_req=0.
- FSM states:
  - IDLE: with an access active, drive data_req=1 and o_stallreq=1. Go to WAIT when data_addr_ok=1; otherwise hold the request unchanged.
  - WAIT: data_req=0, o_stallreq=1. On data_data_ok, capture data_rdata into rbuf and go to DONE.
  - DONE: o_stallreq=0; results come from rbuf. Go to IDLE when stall[4]==`NoStop`, otherwise hold.
- While in IDLE or WAIT with a load, o_write_regfile=0, so no forwarding of stale data.
- In DONE, a load drives o_write_regfile=i_write_regfile and o_wdata=extended rbuf. A store drives o_write_regfile=0.
- Bus fields: data_addr=i_da, data_wr=store op, data_size from op.
- Store steering, with a=i_da[1:0]:
  - SB: wstrb=1<<a, wdata={4{i_db[7:0]}}
  - SH: wstrb=a[1]?1100:0011, wdata={2{i_db[15:0]}}
  - SW: wstrb=1111, wdata=i_db
- Load extraction: select the byte at a (or the half at a[1]). LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- data_data_ok never arrives in the same cycle as data_addr_ok for the same request; an early data_data_ok in IDLE is ignored.
- Reset: the FSM goes to IDLE and rbuf clears to `ZeroWord`. The bus slave shares the reset, so an outstanding transaction is abandoned.

## Timing
- Reset values: data_req=0, o_stallreq=0, o_adel=0, o_ades=0, o_badvaddr=0. Result outputs follow the pass-through path of the zeroed EXE/MEM inputs, so o_write_regfile=0, o_rn=0, o_wdata=0.
- Non-memory instruction: 0 cycles.
- Access: 1 cycle in IDLE, plus N extra IDLE cycles for addr_ok wait, plus M WAIT cycles, plus 1 cycle in DONE. With zero-wait addr_ok and next-cycle data_ok, that is 3 cycles.
- o_stallreq falls on the DONE cycle. The EXE/MEM register advances at the end of that cycle, and MEM/WB captures the result in the same cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - Misalignment is LH/LHU/SH with a[0]=1, or LW/SW with a!=0.
  - A misaligned access issues no request, keeps the FSM in IDLE and drives o_stallreq=0 and o_write_regfile=0.
  - It raises o_adel (load) or o_ades (store) combinationally, with o_badvaddr=i_da.
- Undefined: o_adel, o_ades and o_badvaddr are tied 0, and data_addr low bits are forced aligned for the size (half: [0]=0, word: [1:0]=0).

## Structure
- `global_define.vh` holds `Stop`/`NoStop`, `ZeroWord`, the mem_control op encodings, and the data_size codes.
- Sub-module mem_align: combinational store steering (wstrb/wdata) and load extraction/extension. mem_stage holds the FSM, rbuf and muxing.

## Test plan
- ALU op, i_da=0x1234 → o_wdata=0x1234 the same cycle, o_stallreq=0, data_req=0.
- LB at 0x1003, rdata=0x80FF_FF00, addr_ok immediate, data_ok next cycle → stall for 2 cycles, then o_wdata=0xFFFF_FF80. LBU gives 0x0000_0080.
- SH at 0x2002, i_db=0xAAAA_BEEF → wstrb=1100, wdata=0xBEEF_BEEF, data_wr=1, o_write_regfile=0 in DONE.
- addr_ok held low for 3 cycles → data_req held with a stable address, o_stallreq=1 throughout, a single transaction issued.
- Reset asserted in WAIT → next cycle FSM in IDLE, o_stallreq=0, data_req=0. A late data_data_ok is ignored.
- With MEM_ALIGN_CHECK_EN: LW at 0x3001 → o_adel=1, o_badvaddr=0x3001, data_req=0, o_stallreq=0.
